// File: rtl/seg7_pkg.sv
// Seven-segment pattern constants and segment-bit ordering shared by the scan decoder.
package seg7_pkg;

  // seg_n[6] is segment A down to seg_n[0] as segment G.
  typedef enum int unsigned {
    SEG_G = 0,
    SEG_F = 1,
    SEG_E = 2,
    SEG_D = 3,
    SEG_C = 4,
    SEG_B = 5,
    SEG_A = 6
  } seg_bit_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low cathode pattern for each hex nibble, indexed by nibble value.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse seven-segment lookup: cathode pattern to nibble plus hex/blank classification.
// Purely combinational, zero latency, no flow control.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o,
  output logic       is_blank_o
);

  always_comb begin
    nibble_o = '0;
    is_hex_o = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg_n_i == SEG_PAT[k]) begin
        nibble_o = 4'(k);
        is_hex_o = 1'b1;
      end
    end
  end

  assign is_blank_o = (seg_n_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers digit values from a multiplexed 7-seg bus by committing stable per-digit patterns.
// Commit results visible one clock after the qualifying sample; no backpressure (strobe-driven).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic                  clr_err,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  frame_done,
  output logic                  err_pattern,
  output logic                  err_multi_an
);

  localparam int         IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

  logic [IDX_W-1:0]    trk_idx_q, trk_idx_d;
  logic [6:0]          trk_pat_q, trk_pat_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                frame_q, frame_d;
  logic                errp_q, errp_d;
  logic                errm_q, errm_d;

  logic [DIGITS-1:0]   an_low;
  logic                an_one;
  logic [IDX_W-1:0]    an_idx;
  logic [3:0]          dec_nib;
  logic                dec_hex;
  logic                dec_blank;
  logic                commit;

  seg7_pattern_decode u_decode (
    .seg_n_i    (seg_n),
    .nibble_o   (dec_nib),
    .is_hex_o   (dec_hex),
    .is_blank_o (dec_blank)
  );

  assign an_low = ~an_n;
  assign an_one = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);

  always_comb begin
    an_idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (an_low[k]) an_idx = IDX_W'(k);
    end
  end

  always_comb begin
    trk_idx_d = trk_idx_q;
    trk_pat_d = trk_pat_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    mask_d    = mask_q;
    frame_d   = 1'b0;
    errp_d    = errp_q;
    errm_d    = errm_q;
    commit    = 1'b0;

    // Clear first so an error raised in the same cycle takes precedence.
    if (clr_err) begin
      errp_d = 1'b0;
      errm_d = 1'b0;
    end

    if (sample_en) begin
      if (an_low == '0) begin
        cnt_d = '0;
      end else if (!an_one) begin
        cnt_d  = '0;
        errm_d = 1'b1;
      end else if (an_idx == trk_idx_q && seg_n == trk_pat_q) begin
        if (cnt_q < CNT_MAX) begin
          cnt_d  = cnt_q + 4'd1;
          commit = (cnt_d == CNT_MAX);
        end
      end else begin
        trk_idx_d = an_idx;
        trk_pat_d = seg_n;
        cnt_d     = 4'd1;
      end
    end

    if (commit) begin
      if (dec_hex) begin
        val_d[{an_idx, 2'b00} +: 4] = dec_nib;
        valid_d[an_idx]             = 1'b1;
        blank_d[an_idx]             = 1'b0;
      end else if (dec_blank) begin
        valid_d[an_idx] = 1'b0;
        blank_d[an_idx] = 1'b1;
      end else begin
        errp_d          = 1'b1;
        valid_d[an_idx] = 1'b0;
        blank_d[an_idx] = 1'b0;
      end
      mask_d = mask_q | (DIGITS'(1) << an_idx);
      if (mask_d == '1) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trk_idx_q <= '0;
      trk_pat_q <= '0;
      cnt_q     <= '0;
      val_q     <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      mask_q    <= '0;
      frame_q   <= 1'b0;
      errp_q    <= 1'b0;
      errm_q    <= 1'b0;
    end else begin
      trk_idx_q <= trk_idx_d;
      trk_pat_q <= trk_pat_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
      errp_q    <= errp_d;
      errm_q    <= errm_d;
    end
  end

  assign digit_val    = val_q;
  assign digit_valid  = valid_q;
  assign digit_blank  = blank_q;
  assign frame_done   = frame_q;
  assign err_pattern  = errp_q;
  assign err_multi_an = errm_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: run-length reference model compared every cycle, plus directed literal checks.
module tb_seg7_scan_decoder;

  localparam int ND     = 8;
  localparam int STABLE = 4;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [6:0]    seg_n = 7'h7F;
  logic [ND-1:0] an_n = '1;
  logic          clr_err = 1'b0;
  logic [4*ND-1:0] digit_val;
  logic [ND-1:0] digit_valid, digit_blank;
  logic          frame_done, err_pattern, err_multi_an;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  logic [31:0] m_val;
  logic [7:0]  m_valid, m_blank, m_seen;
  logic        m_frame, m_errp, m_errm;
  int          run_len, run_idx, who, lows, code;
  logic [6:0]  run_pat;

  seg7_scan_decoder #(.DIGITS(ND), .STABLE_CNT(STABLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .clr_err      (clr_err),
    .digit_val    (digit_val),
    .digit_valid  (digit_valid),
    .digit_blank  (digit_blank),
    .frame_done   (frame_done),
    .err_pattern  (err_pattern),
    .err_multi_an (err_multi_an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] onehot_n(input int i);
    logic [7:0] v;
    v    = 8'hFF;
    v[i] = 1'b0;
    return v;
  endfunction

  // Returns nibble 0..15, 16 for blank, -1 for an illegal pattern.
  function automatic int classify(input logic [6:0] p);
    int r;
    r = -1;
    for (int k = 0; k < 16; k++) if (p == HEX_TAB[k]) r = k;
    if (p == 7'h7F) r = 16;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_val = '0; m_valid = '0; m_blank = '0; m_seen = '0;
      m_frame = 1'b0; m_errp = 1'b0; m_errm = 1'b0;
      run_len = 0; run_idx = 0; run_pat = '0;
    end else begin
      m_frame = 1'b0;
      if (clr_err) begin
        m_errp = 1'b0;
        m_errm = 1'b0;
      end
      if (sample_en) begin
        lows = $countones(~an_n);
        if (lows == 0) begin
          run_len = 0;
        end else if (lows > 1) begin
          run_len = 0;
          m_errm  = 1'b1;
        end else begin
          for (int k = 0; k < ND; k++) if (!an_n[k]) who = k;
          if (run_len > 0 && who == run_idx && seg_n == run_pat) begin
            run_len++;
          end else begin
            run_idx = who;
            run_pat = seg_n;
            run_len = 1;
          end
          if (run_len == STABLE) begin
            code = classify(seg_n);
            if (code == 16) begin
              m_blank[who] = 1'b1;
              m_valid[who] = 1'b0;
            end else if (code < 0) begin
              m_errp       = 1'b1;
              m_blank[who] = 1'b0;
              m_valid[who] = 1'b0;
            end else begin
              m_val[4*who +: 4] = 4'(code);
              m_valid[who]      = 1'b1;
              m_blank[who]      = 1'b0;
            end
            m_seen[who] = 1'b1;
            if (m_seen == 8'hFF) begin
              m_frame = 1'b1;
              m_seen  = '0;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en)
      check("outputs", {13'b0, digit_val, digit_valid, digit_blank, frame_done, err_pattern, err_multi_an},
                       {13'b0, m_val, m_valid, m_blank, m_frame, m_errp, m_errm});
  end

  task automatic smp(input logic [7:0] an, input logic [6:0] seg, input int n, input logic clr);
    repeat (n) begin
      an_n = an; seg_n = seg; sample_en = 1'b1; clr_err = clr;
      @(negedge clk);
    end
    sample_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    int pulses, last_step, step, r, cur_idx;
    logic [6:0] cur_pat;

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_outputs", {digit_val, digit_valid, digit_blank, frame_done, err_pattern, err_multi_an}, 0);
    rst_n = 1'b1;

    // Stable digit 0 = "2": commit on the 4th sample only
    smp(onehot_n(0), HEX_TAB[2], 3, 1'b0);
    check("d0_before_commit", digit_valid, 8'h00);
    smp(onehot_n(0), HEX_TAB[2], 1, 1'b0);
    check("d0_val", digit_val[3:0], 4'h2);
    check("d0_valid", digit_valid, 8'h01);
    smp(onehot_n(0), HEX_TAB[2], 2, 1'b0);
    check("d0_no_recommit", {frame_done, digit_valid}, 9'h001);

    // Full scan 1..8
    pulses = 0; last_step = -1; step = 0;
    for (int d = 0; d < 8; d++) begin
      for (int s = 0; s < 4; s++) begin
        smp(onehot_n(d), HEX_TAB[d+1], 1, 1'b0);
        if (frame_done) begin pulses++; last_step = step; end
        step++;
      end
    end
    check("scan_val", digit_val, 32'h87654321);
    check("scan_valid", digit_valid, 8'hFF);
    check("frame_pulses", pulses, 1);
    check("frame_on_last", last_step, 31);
    check("model_scan_val", m_val, 32'h87654321);

    // Multi-anode error and count clearing
    smp(onehot_n(1), HEX_TAB[15], 2, 1'b0);
    smp(8'hFC, HEX_TAB[15], 1, 1'b0);
    check("multi_set", err_multi_an, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("multi_clr", err_multi_an, 0);
    smp(onehot_n(1), HEX_TAB[15], 2, 1'b0);
    check("multi_count_reset", digit_val[7:4], 4'h2);
    smp(onehot_n(1), HEX_TAB[15], 2, 1'b0);
    check("d1_F", digit_val[7:4], 4'hF);
    smp(8'hFC, HEX_TAB[0], 1, 1'b0);
    smp(8'hFC, HEX_TAB[0], 1, 1'b1);
    check("multi_wins_clr", err_multi_an, 1);
    smp(8'hFF, 7'h7F, 1, 1'b1);
    check("multi_clr2", err_multi_an, 0);

    // Digit 3: A, then blank, then illegal
    smp(onehot_n(3), HEX_TAB[10], 4, 1'b0);
    check("d3_A", {digit_valid[3], digit_val[15:12]}, 5'h1A);
    smp(onehot_n(3), 7'b1111111, 4, 1'b0);
    check("d3_blank", {digit_blank[3], digit_valid[3], digit_val[15:12]}, 6'h2A);
    smp(onehot_n(3), 7'b1010101, 4, 1'b0);
    check("d3_illegal", {err_pattern, digit_blank[3], digit_valid[3], digit_val[15:12]}, 7'h4A);

    // Pattern change restarts the run
    smp(onehot_n(2), HEX_TAB[12], 3, 1'b0);
    smp(onehot_n(2), HEX_TAB[13], 1, 1'b0);
    check("change_no_commit", digit_val[11:8], 4'h3);
    smp(onehot_n(2), HEX_TAB[13], 2, 1'b0);
    check("change_count1", digit_val[11:8], 4'h3);
    smp(onehot_n(2), HEX_TAB[13], 1, 1'b0);
    check("change_commit", digit_val[11:8], 4'hD);

    // Reset mid-run discards partial count
    smp(onehot_n(4), HEX_TAB[14], 3, 1'b0);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    check("midrun_reset", {digit_val, digit_valid, digit_blank, frame_done, err_pattern, err_multi_an}, 0);
    smp(onehot_n(4), HEX_TAB[14], 3, 1'b0);
    check("post_reset_3", digit_valid, 8'h00);
    smp(onehot_n(4), HEX_TAB[14], 1, 1'b0);
    check("post_reset_commit", {digit_valid, digit_val}, {8'h10, 32'h000E0000});

    // Randomized traffic with persistent runs
    cur_idx = 0; cur_pat = HEX_TAB[0];
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        cur_idx = $urandom_range(0, 7);
        r = $urandom_range(0, 19);
        if (r < 16) cur_pat = HEX_TAB[r];
        else if (r < 18) cur_pat = 7'h7F;
        else cur_pat = 7'($urandom);
      end
      r = $urandom_range(0, 19);
      if (r < 16) an_n = onehot_n(cur_idx);
      else if (r < 18) an_n = 8'hFF;
      else an_n = onehot_n(cur_idx) & onehot_n($urandom_range(0, 7));
      seg_n     = cur_pat;
      sample_en = ($urandom_range(0, 9) < 7);
      clr_err   = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; sample_en = 1'b0; clr_err = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
